// File: rtl/apb_master_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_pkg
// Description : Shared widths, FSM state encoding and helpers for the
//               APB3 requester sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_master_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Requester transfer phases
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // APB transfers are word-sized; any set low address bit is rejected
    function automatic logic addr_misaligned(input logic [APB_ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_seq_if
// Description : Command/response handshake and APB3 bus signals of the
//               requester sequencer. "master" is the requester view,
//               "slave" is the view of everything around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_seq_if;
    import apb_master_pkg::*;

    // command port
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [APB_ADDR_W-1:0] cmd_addr;
    logic [APB_DATA_W-1:0] cmd_wdata;

    // response port
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [APB_DATA_W-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB3 bus
    logic                  M_PSEL;
    logic                  M_PENABLE;
    logic                  M_PWRITE;
    logic [APB_ADDR_W-1:0] M_PADDR;
    logic [APB_DATA_W-1:0] M_PWDATA;
    logic                  M_PREADY;
    logic                  M_PSLVERR;
    logic [APB_DATA_W-1:0] M_PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               M_PREADY, M_PSLVERR, M_PRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               M_PREADY, M_PSLVERR, M_PRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA
    );

endinterface
`default_nettype wire

// File: rtl/apb_master_seq_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : apb_timeout_cnt
// Description : ACCESS-phase wait-state counter. expire_o flags the cycle in
//               which one more stalled cycle would reach TIMEOUT_CYCLES.
//               TIMEOUT_CYCLES = 0 removes the counter entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic clear_i,
    input  wire logic enable_i,
    output logic      expire_o
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_enabled
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             w_expire;

            // Counter already holds TIMEOUT_CYCLES-1 stalls: this stall is the last allowed
            assign w_expire = enable_i && (cnt_q == C_LAST);
            assign expire_o = w_expire;

            // Next count: clear wins, saturate once expired
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (enable_i && !w_expire) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Count register
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk_i, rst_i, clear_i, enable_i};
            assign expire_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_seq.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_seq
// Description : APB3 requester. Takes one command at a time, runs the
//               SETUP/ACCESS phases, returns data/error on a held response
//               port. Stalled completers are aborted after TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_seq
    import apb_master_pkg::*;
#(
    parameter int                    TIMEOUT_CYCLES = 256,
    parameter logic [APB_ADDR_W-1:0] ADDR_BASE      = 32'h0000_0000
) (
    input  wire logic         S_CLK,
    input  wire logic         S_RST,
    apb_master_seq_if.master  bus
);

    apb_state_e            state_q,       state_d;
    logic                  cmd_ready_q,   cmd_ready_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [APB_DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [APB_ADDR_W-1:0] paddr_q,       paddr_d;
    logic [APB_DATA_W-1:0] pwdata_q,      pwdata_d;

    logic w_cnt_clear;
    logic w_cnt_en;
    logic w_expire;

    // Stall counter only runs while ACCESS waits on PREADY
    assign w_cnt_en = (state_q == ST_ACCESS) && !bus.M_PREADY;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (S_CLK),
        .rst_i    (S_RST),
        .clear_i  (w_cnt_clear),
        .enable_i (w_cnt_en),
        .expire_o (w_expire)
    );

    // Next state and next values of every registered output
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        w_cnt_clear   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    if (addr_misaligned(bus.cmd_addr)) begin
                        // Rejected locally; the bus never sees this command
                        state_d       = ST_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d     = ST_SETUP;
                        psel_d      = 1'b1;
                        penable_d   = 1'b0;
                        pwrite_d    = bus.cmd_write;
                        paddr_d     = bus.cmd_addr + ADDR_BASE;
                        pwdata_d    = bus.cmd_write ? bus.cmd_wdata : '0;
                        w_cnt_clear = 1'b1;
                    end
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
                // A completing PREADY takes priority over an expiring counter
                if (bus.M_PREADY) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = bus.M_PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !bus.M_PSLVERR) ? bus.M_PRDATA : '0;
                end else if (w_expire) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus and any pending response at once
    always_ff @(posedge S_CLK or posedge S_RST) begin
        if (S_RST) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.M_PSEL      = psel_q;
    assign bus.M_PENABLE   = penable_q;
    assign bus.M_PWRITE    = pwrite_q;
    assign bus.M_PADDR     = paddr_q;
    assign bus.M_PWDATA    = pwdata_q;

endmodule
`default_nettype wire
